// File: rtl/tile_pkg.sv
// Shared constants, FSM state type and slot packing helpers for the tile shuffler.
package tile_pkg;

  localparam int EDGE_N   = 24;
  localparam int CENTER_N = 12;
  localparam int IDX_W    = 5;
  localparam int LFSR_W   = 16;

  localparam logic [LFSR_W-1:0] LFSR_TAPS    = 16'hB400;
  localparam logic [LFSR_W-1:0] SEED_DEFAULT = 16'hACE1;

  typedef enum logic [2:0] {IDLE, INIT, EDGE, CENTER, PUBLISH} tile_state_e;

  typedef logic [IDX_W-1:0] edge_arr_t   [EDGE_N];
  typedef logic [IDX_W-1:0] center_arr_t [CENTER_N];

  // Slot n occupies bits [IDX_W*n +: IDX_W] of the packed order.
  function automatic logic [EDGE_N*IDX_W-1:0] pack_edge(input edge_arr_t a);
    logic [EDGE_N*IDX_W-1:0] v;
    v = '0;
    for (int n = 0; n < EDGE_N; n++) v[n*IDX_W +: IDX_W] = a[n];
    return v;
  endfunction

  function automatic logic [CENTER_N*IDX_W-1:0] pack_center(input center_arr_t a);
    logic [CENTER_N*IDX_W-1:0] v;
    v = '0;
    for (int n = 0; n < CENTER_N; n++) v[n*IDX_W +: IDX_W] = a[n];
    return v;
  endfunction

  // Extracts one slot; center orders are zero-extended to the edge width by the caller.
  function automatic logic [IDX_W-1:0] slot_of(input logic [EDGE_N*IDX_W-1:0] v, input int n);
    return v[n*IDX_W +: IDX_W];
  endfunction

endpackage

// File: rtl/tile_shuffle_ctrl_if.sv
// Request/result bundle between the shuffle sequencer and board/render logic.
interface tile_shuffle_ctrl_if;
  import tile_pkg::*;

  logic                       start;
  logic                       seed_load;
  logic [LFSR_W-1:0]          seed_in;
  logic                       busy;
  logic                       done;
  logic                       valid;
  logic [EDGE_N*IDX_W-1:0]    edge_order;
  logic [CENTER_N*IDX_W-1:0]  center_order;

  modport master (
    output start, seed_load, seed_in,
    input  busy, done, valid, edge_order, center_order
  );

  modport slave (
    input  start, seed_load, seed_in,
    output busy, done, valid, edge_order, center_order
  );

endinterface

// File: rtl/tile_lfsr.sv
// Free-running 16-bit Galois LFSR with seed load; a zero seed is replaced by SEED
// so the register can never lock up in the all-zero state.
module tile_lfsr
  import tile_pkg::*;
#(
  parameter int              W    = LFSR_W,
  parameter logic [W-1:0]    TAPS = LFSR_TAPS,
  parameter logic [W-1:0]    SEED = SEED_DEFAULT
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic [7:0]   rnd
);

  logic [W-1:0] lfsr_q;

  // Shift every cycle unless a seed is being loaded.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      lfsr_q <= SEED;
    else if (load)
      lfsr_q <= (load_val == '0) ? SEED : load_val;
    else
      lfsr_q <= (lfsr_q >> 1) ^ (lfsr_q[0] ? TAPS : '0);
  end

  assign rnd = lfsr_q[W-1 -: 8];

endmodule

// File: rtl/tile_shuffle_ctrl.sv
// Fisher-Yates shuffle sequencer: 23 edge swaps, then 11 center swaps, then a
// single-cycle publish so consumers only ever see complete permutations.
module tile_shuffle_ctrl
  import tile_pkg::*;
#(
  parameter logic [LFSR_W-1:0] SEED = SEED_DEFAULT
) (
  input  logic                clk,
  input  logic                rst_n,
  tile_shuffle_ctrl_if.slave  bus
);

  localparam int EW = $clog2(EDGE_N);
  localparam int CW = $clog2(CENTER_N);

  tile_state_e                state, state_nxt;
  logic [IDX_W-1:0]           i_q;
  logic [IDX_W-1:0]           j;
  logic [7:0]                 rnd;
  logic                       seed_ld;
  logic                       done_q;
  logic                       valid_q;
  logic [EDGE_N*IDX_W-1:0]    edge_q;
  logic [CENTER_N*IDX_W-1:0]  center_q;
  edge_arr_t                  work_e;
  center_arr_t                work_c;

  // Seeding is only honoured between shuffles.
  assign seed_ld = bus.seed_load && (state == IDLE);

  tile_lfsr #(.SEED(SEED)) u_lfsr (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (seed_ld),
    .load_val (bus.seed_in),
    .rnd      (rnd)
  );

  // j = floor(rnd * (i+1) / 256) is always within 0..i without a divider.
  assign j = IDX_W'((({5'd0, rnd}) * ({8'd0, i_q} + 13'd1)) >> 8);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state: fixed-length walk through both swap phases.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.start) state_nxt = INIT;
      INIT:    state_nxt = EDGE;
      EDGE:    if (i_q == IDX_W'(1)) state_nxt = CENTER;
      CENTER:  if (i_q == IDX_W'(1)) state_nxt = PUBLISH;
      PUBLISH: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Index counter and published outputs; outputs move only in PUBLISH.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      i_q      <= '0;
      done_q   <= 1'b0;
      valid_q  <= 1'b0;
      edge_q   <= '0;
      center_q <= '0;
    end else begin
      done_q <= (state == PUBLISH);
      case (state)
        INIT:    i_q <= IDX_W'(EDGE_N - 1);
        EDGE:    i_q <= (i_q == IDX_W'(1)) ? IDX_W'(CENTER_N - 1) : i_q - IDX_W'(1);
        CENTER:  i_q <= i_q - IDX_W'(1);
        PUBLISH: begin
          edge_q   <= pack_edge(work_e);
          center_q <= pack_center(work_c);
          valid_q  <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Working arrays: identity fill, then one swap per cycle; rebuilt on every INIT.
  always_ff @(posedge clk) begin
    case (state)
      INIT: begin
        for (int n = 0; n < EDGE_N; n++)   work_e[n] <= IDX_W'(n);
        for (int n = 0; n < CENTER_N; n++) work_c[n] <= IDX_W'(n);
      end
      EDGE: begin
        work_e[i_q[EW-1:0]] <= work_e[j[EW-1:0]];
        work_e[j[EW-1:0]]   <= work_e[i_q[EW-1:0]];
      end
      CENTER: begin
        work_c[i_q[CW-1:0]] <= work_c[j[CW-1:0]];
        work_c[j[CW-1:0]]   <= work_c[i_q[CW-1:0]];
      end
      default: ;
    endcase
  end

  assign bus.busy         = (state != IDLE);
  assign bus.done         = done_q;
  assign bus.valid        = valid_q;
  assign bus.edge_order   = edge_q;
  assign bus.center_order = center_q;

endmodule

// File: tb/tb_tile_shuffle_ctrl.sv
// Scoreboard bench for tile_shuffle_ctrl: a bench-side LFSR and Fisher-Yates model
// predicts each published layout at the moment start is accepted.
module tb_tile_shuffle_ctrl;
  import tile_pkg::*;

  localparam int LAT = 36;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;

  tile_shuffle_ctrl_if bus();

  tile_shuffle_ctrl dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [119:0] e;
    logic [59:0]  c;
    int           done_cyc;
  } exp_t;

  exp_t sb[$];

  int           total = 0;
  int           bad   = 0;
  int           cyc   = 0;
  logic [15:0]  m_lfsr = 16'hACE1;
  int           m_cnt = 0;
  logic         m_valid = 1'b0;
  logic [119:0] m_pub_e = '0;
  logic [59:0]  m_pub_c = '0;
  logic [119:0] last_exp_e;
  logic [59:0]  last_exp_c;
  logic [119:0] last_obs_e;
  logic [59:0]  last_obs_c;
  int           last_acc_cyc = 0;
  int           obs_done_cyc = 0;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [15:0] step(input logic [15:0] v);
    return {1'b0, v[15:1]} ^ (v[0] ? 16'hB400 : 16'h0000);
  endfunction

  // v0 is the LFSR value right after the accepting edge; each swap consumes one further step.
  function automatic void model(input logic [15:0] v0, output logic [119:0] eo, output logic [59:0] co);
    int e[24];
    int c[12];
    logic [15:0] v;
    int j, t;
    v = v0;
    for (int n = 0; n < 24; n++) e[n] = n;
    for (int n = 0; n < 12; n++) c[n] = n;
    for (int i = 23; i >= 1; i--) begin
      v = step(v);
      j = (int'(v[15:8]) * (i + 1)) >> 8;
      t = e[i]; e[i] = e[j]; e[j] = t;
    end
    for (int i = 11; i >= 1; i--) begin
      v = step(v);
      j = (int'(v[15:8]) * (i + 1)) >> 8;
      t = c[i]; c[i] = c[j]; c[j] = t;
    end
    eo = '0;
    co = '0;
    for (int n = 0; n < 24; n++) eo[5*n +: 5] = 5'(e[n]);
    for (int n = 0; n < 12; n++) co[5*n +: 5] = 5'(c[n]);
  endfunction

  function automatic logic perm_ok(input logic [119:0] v, input int n);
    logic [31:0] seen;
    int val;
    seen = '0;
    for (int s = 0; s < n; s++) begin
      val = int'(slot_of(v, s));
      if (val >= n || seen[val]) return 1'b0;
      seen[val] = 1'b1;
    end
    return 1'b1;
  endfunction

  task automatic monitor();
    logic exp_done;
    exp_done = (sb.size() > 0) && (sb[0].done_cyc == cyc);
    if (bus.done) obs_done_cyc = cyc;
    chk("busy", bus.busy, m_cnt > 0);
    chk("done", bus.done, exp_done);
    if (exp_done) begin
      m_pub_e = sb[0].e;
      m_pub_c = sb[0].c;
      m_valid = 1'b1;
      sb.pop_front();
      last_obs_e = bus.edge_order;
      last_obs_c = bus.center_order;
      chk("edge_perm", perm_ok(bus.edge_order, 24), 1'b1);
      chk("center_perm", perm_ok({60'd0, bus.center_order}, 12), 1'b1);
    end
    chk("valid", bus.valid, m_valid);
    chk("edge_order", bus.edge_order, m_pub_e);
    chk("center_order", bus.center_order, m_pub_c);
  endtask

  task automatic tick();
    logic idle;
    exp_t x;
    @(posedge clk);
    cyc++;
    if (rst_n) begin
      idle = (m_cnt == 0);
      if (bus.seed_load && idle) m_lfsr = (bus.seed_in == 16'h0) ? 16'hACE1 : bus.seed_in;
      else                       m_lfsr = step(m_lfsr);
      if (m_cnt > 0) m_cnt--;
      if (bus.start && idle) begin
        model(m_lfsr, x.e, x.c);
        x.done_cyc = cyc + LAT;
        sb.push_back(x);
        last_exp_e   = x.e;
        last_exp_c   = x.c;
        last_acc_cyc = cyc;
        m_cnt        = LAT;
      end
    end
    #1;
    if (rst_n) monitor();
  endtask

  task automatic apply_reset();
    rst_n   = 1'b0;
    m_lfsr  = 16'hACE1;
    m_cnt   = 0;
    m_valid = 1'b0;
    m_pub_e = '0;
    m_pub_c = '0;
    sb.delete();
    #1;
    chk("rst_busy", bus.busy, 1'b0);
    chk("rst_done", bus.done, 1'b0);
    chk("rst_valid", bus.valid, 1'b0);
    chk("rst_edge", bus.edge_order, '0);
    chk("rst_center", bus.center_order, '0);
  endtask

  task automatic wait_idle(input int pulse_at);
    int n;
    n = 0;
    while (sb.size() > 0 && n < 60) begin
      n++;
      bus.start = (n == pulse_at);
      tick();
    end
    bus.start = 1'b0;
    chk("done_timeout", sb.size(), 0);
    sb.delete();
    tick();
  endtask

  task automatic run(input logic [15:0] seed, input int delay, input int pulse_at);
    obs_done_cyc = -1000;
    bus.seed_in   = seed;
    bus.seed_load = 1'b1;
    bus.start     = (delay == 0);
    tick();
    bus.seed_load = 1'b0;
    bus.start     = 1'b0;
    if (seed == 16'h0) chk("zero_seed_lfsr", dut.u_lfsr.lfsr_q, 16'hACE1);
    if (delay > 0) begin
      repeat (delay - 1) tick();
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
    end
    wait_idle(pulse_at);
    chk("latency", obs_done_cyc - last_acc_cyc, LAT);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [119:0] ref_e, e2, ea;
    logic [59:0]  ref_c;
    bus.start     = 1'b0;
    bus.seed_load = 1'b0;
    bus.seed_in   = '0;

    // Reset, then idle.
    #2;
    apply_reset();
    repeat (3) tick();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) tick();

    // Post-reset shuffle accepted on the 6th edge after release.
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    ref_e = last_exp_e;
    ref_c = last_exp_c;
    wait_idle(0);

    // Seed 1, start one cycle after load.
    run(16'h0001, 1, 0);
    e2 = last_exp_e;

    // Same again with a stray start 10 cycles in.
    run(16'h0001, 1, 10);
    chk("restart_ignored", last_obs_e, e2);

    // Zero seed behaves like the reset seed with identical start timing.
    run(16'h0000, 6, 0);
    chk("zero_seed_edge", last_obs_e, ref_e);
    chk("zero_seed_center", last_obs_c, ref_c);

    // Seed load and start on the same edge.
    run(16'h1234, 0, 0);

    // Reset in the middle of a shuffle.
    bus.seed_in   = 16'h5A5A;
    bus.seed_load = 1'b1;
    tick();
    bus.seed_load = 1'b0;
    bus.start     = 1'b1;
    tick();
    bus.start     = 1'b0;
    repeat (19) tick();
    apply_reset();
    repeat (2) begin
      tick();
      chk("rst_hold_done", bus.done, 1'b0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (40) tick();
    run(16'hBEEF, 2, 0);

    // Repeatability and sensitivity to start timing.
    run(16'h7777, 4, 0);
    ea = last_exp_e;
    run(16'h7777, 4, 0);
    chk("repeat_same", last_obs_e, ea);
    run(16'h7777, 5, 0);
    chk("delay_changes_edge", last_obs_e != ea, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
